notgate_responder: RTL and testbench
====================================

Name: notgate_responder

Overview:
- Far-end responder for the NOT-gate stimulus/check loop: the stand-in DUT side that the checker drives and samples.
- Receives the checker's toggling stimulus and returns its logical inverse after a fixed, parameterised latency.
- Counts stimulus transitions over one packet and signals completion.
- Optionally corrupts every Nth response, so the checker's error counter can be validated against a known count.

Parameters:
- PKG_LEN, 65536: stimulus transitions per packet. Matches the checker's 65536 sends (its counter runs 0..65535).
- LATENCY, 1: clock cycles from an RSP_IN change to the matching RSP_OUT change. Legal values are 1 or 2, so the response lands inside the checker's 3-cycle sample window.
- INJ_PERIOD, 16: corrupt every INJ_PERIOD-th transition. 0 disables injection. Used only with RSP_INJECT_EN.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- RSP_START  in  1  one-cycle arm pulse. Honoured only in IDLE.
- RSP_FINISH  out  1  one-cycle pulse when a packet completes.
- RSP_IN  in  1  stimulus from the checker, synchronous to sys_clk.
- RSP_OUT  out  1  response to the checker: ~RSP_IN delayed LATENCY cycles, unless corrupted.
- RSP_EDGES  out  32  stimulus transitions counted in the current or last packet.
- RSP_INJECTED  out  32  responses corrupted in the current or last packet.

Behaviour:
- Reset (async, sys_rst=1):
  - State goes to IDLE.
  - in_d=0. All delay stages =1, so RSP_OUT=1, i.e. ~0, matching the checker's reset stimulus of 0.
  - RSP_EDGES=0, RSP_INJECTED=0, inj_cnt=0, RSP_FINISH=0.
- Edge detection:
  - in_d registers RSP_IN every cycle.
  - edge = RSP_IN ^ in_d.
- Delay line:
  - Runs in every state, so RSP_OUT always tracks ~RSP_IN.
  - Stage0 <= ~RSP_IN, or RSP_IN when the current edge is corrupted.
  - LATENCY=2 adds one further register stage.
  - An RSP_IN change at cycle t appears on RSP_OUT at cycle t+LATENCY.
- FSM, one-hot, 3 states:
  - IDLE:
    - On RSP_START: clear RSP_EDGES, RSP_INJECTED and inj_cnt, then go to ACTIVE.
    - Otherwise hold. The counters keep the previous packet's values.
  - ACTIVE:
    - Each edge increments RSP_EDGES.
    - When an edge brings RSP_EDGES to PKG_LEN, go to DONE in the same cycle.
    - Edges outside ACTIVE are not counted.
  - DONE:
    - RSP_FINISH=1 for exactly one cycle, then return to IDLE.
    - Counters are frozen.
- Boundary conditions:
  - RSP_START in ACTIVE or DONE is ignored.
  - RSP_START in the same cycle as an edge while in IDLE: the edge is not counted, because counting begins the cycle after the transition to ACTIVE.
  - The final edge is counted in the cycle it arrives.
  - A final edge that is also an injection point is corrupted and counted as injected.
  - Edges arriving in DONE are not counted.
  - RSP_EDGES cannot wrap, since PKG_LEN < 2^32. A PKG_LEN of 0 is illegal.
  - sys_rst mid-packet aborts immediately, with all values returning to their reset values.

Optional Feature:
- Macro: RSP_INJECT_EN.
- Defined, with INJ_PERIOD>0:
  - In ACTIVE, each edge increments inj_cnt (16-bit).
  - When an edge arrives with inj_cnt==INJ_PERIOD-1: stage0 takes the non-inverted RSP_IN, inj_cnt clears to 0, and RSP_INJECTED increments.
  - The checker must then report floor(PKG_LEN/INJ_PERIOD) errors.
- Undefined:
  - No injection logic is built.
  - RSP_OUT is always ~RSP_IN delayed.
  - RSP_INJECTED is tied to 0.

Decomposition:
- Package notgate_pkg holds:
  - state encodings RSP_IDLE=3'b001, RSP_ACTIVE=3'b010, RSP_DONE=3'b100;
  - default PKG_LEN;
  - LATENCY_MIN=1 and LATENCY_MAX=2.
- One sub-module, rsp_delay_line:
  - parameterised depth, 1-bit shift register;
  - async active-high reset to 1;
  - input already inverted/corrupted by the parent.

Test Plan:
- Reset release, RSP_IN=0 held -> RSP_OUT=1, RSP_EDGES=0, RSP_FINISH=0, state IDLE.
- LATENCY=1, toggle RSP_IN at cycle 10 -> RSP_OUT flips at cycle 11. LATENCY=2 -> flips at cycle 12.
- Feature off, START, then the checker drives 65536 toggles -> RSP_EDGES=65536, one RSP_FINISH pulse, checker error count 0, RSP_INJECTED=0.
- RSP_INJECT_EN, INJ_PERIOD=16, full packet:
  - RSP_INJECTED=4096 and the checker error count is 4096.
  - Edges 16, 32, ... return RSP_OUT==RSP_IN.
- sys_rst asserted after 100 edges, then released:
  - all outputs are at reset values asynchronously;
  - a new START counts from 0.
- Boundary cases:
  - RSP_START pulsed during ACTIVE -> ignored, count continues.
  - Toggles after DONE -> RSP_EDGES stays 65536.

Source files
------------

// File: rtl/notgate_pkg.sv
// Shared definitions for the NOT-gate responder: FSM encodings and parameter limits.
package notgate_pkg;

  // One-hot responder states.
  typedef enum logic [2:0] {
    RSP_IDLE   = 3'b001,
    RSP_ACTIVE = 3'b010,
    RSP_DONE   = 3'b100
  } rsp_state_e;

  // Default packet length, matching the checker's 65536 sends.
  localparam int unsigned DEF_PKG_LEN = 65536;

  // Response latency bounds that keep the reply inside the checker's sample window.
  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 2;

endpackage

// File: rtl/rsp_delay_line.sv
// 1-bit shift register of configurable depth; every stage resets to 1.
module rsp_delay_line #(
  parameter int unsigned Depth = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Depth-1:0] stage_q, stage_d;

  // Shift the new sample into stage 0 and move older samples along.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = d_i;
    for (int i = 1; i < int'(Depth); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers, reset high so the output idles at ~0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '1;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/notgate_responder.sv
// Far-end responder for the NOT-gate stimulus/check loop: returns ~RSP_IN after LATENCY
// cycles, counts stimulus transitions per packet and pulses RSP_FINISH on completion.
// Optional feature macro: RSP_INJECT_EN (corrupt every INJ_PERIOD-th response).
module notgate_responder
  import notgate_pkg::*;
#(
  parameter int unsigned PKG_LEN    = DEF_PKG_LEN,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned INJ_PERIOD = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        RSP_START,
  output logic        RSP_FINISH,
  input  logic        RSP_IN,
  output logic        RSP_OUT,
  output logic [31:0] RSP_EDGES,
  output logic [31:0] RSP_INJECTED
);

  localparam logic [31:0] PkgLenW = 32'(PKG_LEN);

  rsp_state_e  state_q, state_d;
  logic [31:0] edges_q, edges_d;
  logic        in_d_q;
  logic        in_edge;
  logic        corrupt;
  logic        stage0_d;

  // Previous-cycle copy of the stimulus for transition detection.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      in_d_q <= 1'b0;
    end else begin
      in_d_q <= RSP_IN;
    end
  end

  assign in_edge = RSP_IN ^ in_d_q;

`ifdef RSP_INJECT_EN
  localparam bit          InjOn   = (INJ_PERIOD != 0);
  localparam logic [15:0] InjLast = InjOn ? 16'(INJ_PERIOD - 1) : 16'd0;

  logic [15:0] inj_cnt_q, inj_cnt_d;
  logic [31:0] injected_q, injected_d;

  assign corrupt = InjOn && (state_q == RSP_ACTIVE) && in_edge && (inj_cnt_q == InjLast);

  // Injection counters: cleared on arm, advanced per counted edge, wrapped at each injection.
  always_comb begin
    inj_cnt_d  = inj_cnt_q;
    injected_d = injected_q;
    if ((state_q == RSP_IDLE) && RSP_START) begin
      inj_cnt_d  = 16'd0;
      injected_d = 32'd0;
    end else if ((state_q == RSP_ACTIVE) && in_edge) begin
      if (corrupt) begin
        inj_cnt_d  = 16'd0;
        injected_d = injected_q + 32'd1;
      end else begin
        inj_cnt_d  = inj_cnt_q + 16'd1;
      end
    end
  end

  // Injection counter registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      inj_cnt_q  <= 16'd0;
      injected_q <= 32'd0;
    end else begin
      inj_cnt_q  <= inj_cnt_d;
      injected_q <= injected_d;
    end
  end

  assign RSP_INJECTED = injected_q;
`else
  assign corrupt      = 1'b0;
  assign RSP_INJECTED = 32'd0;
`endif

  // Packet FSM: arm in IDLE, count edges in ACTIVE, one-cycle finish pulse in DONE.
  always_comb begin
    state_d    = state_q;
    edges_d    = edges_q;
    RSP_FINISH = 1'b0;
    unique case (state_q)
      RSP_IDLE: begin
        if (RSP_START) begin
          edges_d = 32'd0;
          state_d = RSP_ACTIVE;
        end
      end
      RSP_ACTIVE: begin
        if (in_edge) begin
          edges_d = edges_q + 32'd1;
          if (edges_d == PkgLenW) begin
            state_d = RSP_DONE;
          end
        end
      end
      RSP_DONE: begin
        RSP_FINISH = 1'b1;
        state_d    = RSP_IDLE;
      end
      default: begin
        state_d = RSP_IDLE;
      end
    endcase
  end

  // FSM state and edge counter registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= RSP_IDLE;
      edges_q <= 32'd0;
    end else begin
      state_q <= state_d;
      edges_q <= edges_d;
    end
  end

  assign RSP_EDGES = edges_q;

  // A corrupted edge passes the stimulus through uninverted for that one sample.
  assign stage0_d = corrupt ? RSP_IN : ~RSP_IN;

  rsp_delay_line #(
    .Depth(LATENCY)
  ) u_delay (
    .clk_i(sys_clk),
    .rst_i(sys_rst),
    .d_i  (stage0_d),
    .q_o  (RSP_OUT)
  );

endmodule

// File: tb/tb_notgate_responder.sv
// Scoreboard bench: two responders (latency 1 and 2) share one stimulus stream; the expected
// response of each drive is queued and popped when the matching output becomes visible.
module tb_notgate_responder;

  localparam int unsigned PkgLen    = 64;
  localparam int unsigned InjPeriod = 16;
`ifdef RSP_INJECT_EN
  localparam bit InjEn = 1'b1;
`else
  localparam bit InjEn = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rsp_start = 1'b0;
  logic        rsp_in = 1'b0;
  logic        fin1, out1, fin2, out2;
  logic [31:0] edges1, inj1, edges2, inj2;

  notgate_responder #(
    .PKG_LEN   (PkgLen),
    .LATENCY   (1),
    .INJ_PERIOD(InjPeriod)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .RSP_START   (rsp_start),
    .RSP_FINISH  (fin1),
    .RSP_IN      (rsp_in),
    .RSP_OUT     (out1),
    .RSP_EDGES   (edges1),
    .RSP_INJECTED(inj1)
  );

  notgate_responder #(
    .PKG_LEN   (PkgLen),
    .LATENCY   (2),
    .INJ_PERIOD(InjPeriod)
  ) dut_l2 (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .RSP_START   (rsp_start),
    .RSP_FINISH  (fin2),
    .RSP_IN      (rsp_in),
    .RSP_OUT     (out2),
    .RSP_EDGES   (edges2),
    .RSP_INJECTED(inj2)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: 0 = idle, 1 = counting, 2 = finishing.
  int   m_phase;
  int   m_edges;
  int   m_inj;
  int   m_cnt;
  bit   m_prev;
  bit   saw_fin;
  logic q1[$];
  logic q2[$];

  task automatic model_reset();
    m_phase = 0;
    m_edges = 0;
    m_inj   = 0;
    m_cnt   = 0;
    m_prev  = 1'b0;
    q1.delete();
    q2.delete();
    q1.push_back(1'b1);
    q2.push_back(1'b1);
    q2.push_back(1'b1);
  endtask

  // One clock: compare what is visible now, then drive the next stimulus and predict it.
  task automatic cycle(input bit v, input bit st);
    bit toggled;
    bit corrupt;
    @(negedge sys_clk);
    check("out_lat1", out1, q1.pop_front());
    check("out_lat2", out2, q2.pop_front());
    check("edges", edges1, m_edges);
    check("edges_lat2", edges2, m_edges);
    check("finish", fin1, (m_phase == 2));
    check("finish_lat2", fin2, (m_phase == 2));
    check("injected", inj1, m_inj);
    if (fin1) saw_fin = 1'b1;
    rsp_in    = v;
    rsp_start = st;
    toggled   = v ^ m_prev;
    corrupt   = 1'b0;
    if (m_phase == 0) begin
      if (st) begin
        m_edges = 0;
        m_inj   = 0;
        m_cnt   = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (toggled) begin
        m_edges++;
        if (InjEn && InjPeriod != 0) begin
          if (m_cnt == int'(InjPeriod) - 1) begin
            corrupt = 1'b1;
            m_cnt   = 0;
            m_inj++;
          end else begin
            m_cnt++;
          end
        end
        if (m_edges == int'(PkgLen)) m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
    q1.push_back(corrupt ? v : ~v);
    q2.push_back(corrupt ? v : ~v);
    m_prev = v;
  endtask

  bit cur;

  initial begin
    model_reset();
    saw_fin = 1'b0;
    cur     = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    check("rst_out", out1, 1);
    check("rst_edges", edges1, 0);
    check("rst_finish", fin1, 0);
    check("rst_injected", inj1, 0);

    // Idle toggles must not be counted.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) cur = ~cur;
      cycle(cur, 1'b0);
    end

    // Arm with a coincident edge, then run a packet with holds and a stray START.
    cur = ~cur;
    cycle(cur, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      if (i % 3 != 0) cur = ~cur;
      cycle(cur, (i == 20));
      if (m_phase == 2) break;
    end
    // Toggles during and after DONE are ignored.
    for (int i = 0; i < 10; i++) begin
      cur = ~cur;
      cycle(cur, 1'b0);
    end
    check("finish_seen", saw_fin, 1);
    check("edges_final", edges1, PkgLen);
    check("injected_final", inj1, InjEn ? (PkgLen / InjPeriod) : 0);

    // Abort a packet with an asynchronous reset after 20 edges.
    cycle(cur, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cur = ~cur;
      cycle(cur, 1'b0);
    end
    @(negedge sys_clk);
    #2;
    sys_rst = 1'b1;
    rsp_in  = 1'b0;
    cur     = 1'b0;
    #1;
    check("arst_out", out1, 1);
    check("arst_out_lat2", out2, 1);
    check("arst_edges", edges1, 0);
    check("arst_finish", fin1, 0);
    check("arst_injected", inj1, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();

    // A fresh packet counts from zero.
    cycle(cur, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cur = ~cur;
      cycle(cur, 1'b0);
    end
    cycle(cur, 1'b0);
    check("restart_edges", edges1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
